// File: rtl/hazard_stall_controller_if.sv
// hazard_stall_controller_if: hazard-detection inputs from ID/EX and front-end
// sequencing outputs (PC / IF-ID / ID-EX enables and flushes, stall counter).
interface hazard_stall_controller_if #(parameter int CNT_WIDTH = 16);
  logic [4:0]           IFID_Rs;
  logic [4:0]           IFID_Rt;
  logic                 IFID_UsesRt;
  logic                 IDEX_MemRead;
  logic [4:0]           IDEX_WriteReg;
  logic                 Jump_ID;
  logic                 Branch_Taken;
  logic                 Mul_Start;
  logic                 PCWrite;
  logic                 IFIDWrite;
  logic                 IFIDFlush;
  logic                 IDEXWrite;
  logic                 IDEXFlush;
  logic                 State_Busy;
  logic                 Protocol_Err;
  logic [CNT_WIDTH-1:0] StallCycles;
  modport master (
    output IFID_Rs, IFID_Rt, IFID_UsesRt, IDEX_MemRead, IDEX_WriteReg,
           Jump_ID, Branch_Taken, Mul_Start,
    input  PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush,
           State_Busy, Protocol_Err, StallCycles
  );
  modport slave (
    input  IFID_Rs, IFID_Rt, IFID_UsesRt, IDEX_MemRead, IDEX_WriteReg,
           Jump_ID, Branch_Taken, Mul_Start,
    output PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush,
           State_Busy, Protocol_Err, StallCycles
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: load-use stall, branch/jump flush and multiplier hold
// sequencing for the MIPS front end, with a saturating stall-cycle counter.
module hazard_stall_controller #(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_WIDTH   = 16
) (
  input logic                    Clk,
  input logic                    Reset,
  hazard_stall_controller_if.slave bus
);
  typedef enum logic {RUN, MUL_WAIT} state_t;
  // Number of MUL_WAIT cycles after the Mul_Start cycle itself.
  localparam logic [3:0] MUL_LOAD = 4'(MUL_LATENCY - 2);
  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_mul_cnt;
  logic [3:0]           w_mul_cnt_nxt;
  logic [CNT_WIDTH-1:0] r_stall;
  logic                 r_perr;
  logic                 w_perr_set;
  logic                 w_load_use;
  logic                 w_pc;
  logic                 w_ifw;
  logic                 w_iff;
  logic                 w_idw;
  logic                 w_idf;
  logic                 w_busy;
  assign w_load_use = bus.IDEX_MemRead && bus.IDEX_WriteReg != 5'd0 &&
                      (bus.IDEX_WriteReg == bus.IFID_Rs ||
                       (bus.IFID_UsesRt && bus.IDEX_WriteReg == bus.IFID_Rt));
  always_comb begin
    w_state_nxt   = r_state;
    w_mul_cnt_nxt = r_mul_cnt;
    w_perr_set    = 1'b0;
    w_pc          = 1'b1;
    w_ifw         = 1'b1;
    w_idw         = 1'b1;
    w_iff         = 1'b0;
    w_idf         = 1'b0;
    w_busy        = 1'b0;
    if (Reset) begin
      w_pc  = 1'b0;
      w_ifw = 1'b0;
      w_idw = 1'b0;
      w_iff = 1'b1;
      w_idf = 1'b1;
    end else if (r_state == MUL_WAIT) begin
      w_pc          = 1'b0;
      w_ifw         = 1'b0;
      w_idw         = 1'b0;
      w_busy        = 1'b1;
      w_perr_set    = bus.Mul_Start | bus.Branch_Taken;
      w_mul_cnt_nxt = r_mul_cnt - 4'd1;
      w_state_nxt   = (r_mul_cnt == 4'd1) ? RUN : MUL_WAIT;
    end else if (bus.Branch_Taken) begin
      w_iff      = 1'b1;
      w_idf      = 1'b1;
      w_perr_set = bus.Mul_Start;
    end else if (bus.Mul_Start) begin
      w_pc          = 1'b0;
      w_ifw         = 1'b0;
      w_idw         = 1'b0;
      w_mul_cnt_nxt = MUL_LOAD;
      w_state_nxt   = (MUL_LOAD == 4'd0) ? RUN : MUL_WAIT;
    end else if (w_load_use) begin
      w_pc  = 1'b0;
      w_ifw = 1'b0;
      w_idf = 1'b1;
    end else begin
      w_iff = bus.Jump_ID;
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= RUN;
      r_mul_cnt <= '0;
      r_stall   <= '0;
      r_perr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mul_cnt <= w_mul_cnt_nxt;
      r_perr    <= r_perr | w_perr_set;
      r_stall   <= (!w_pc && r_stall != '1) ? r_stall + 1'b1 : r_stall;
    end
  end
  assign bus.PCWrite      = w_pc;
  assign bus.IFIDWrite    = w_ifw;
  assign bus.IFIDFlush    = w_iff;
  assign bus.IDEXWrite    = w_idw;
  assign bus.IDEXFlush    = w_idf;
  assign bus.State_Busy   = w_busy;
  assign bus.Protocol_Err = r_perr;
  assign bus.StallCycles  = r_stall;
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: directed stimulus, a cycle-level behavioural model
// compared on every negedge, plus hand-computed literal expectations.
module tb_hazard_stall_controller;
  localparam int MUL_LATENCY = 4;
  localparam int CNT_WIDTH   = 16;
  localparam int CNT_MAX     = (1 << CNT_WIDTH) - 1;
  logic Clk = 1'b0;
  logic Reset;
  int   n_checks = 0;
  int   n_err = 0;
  bit   run = 1'b0;
  int   m_hold = 0;
  bit   m_err = 1'b0;
  int   m_cnt = 0;
  hazard_stall_controller_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();
  hazard_stall_controller #(.MUL_LATENCY(MUL_LATENCY), .CNT_WIDTH(CNT_WIDTH)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );
  always #5 Clk = ~Clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask
  // Expected {PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXFlush, State_Busy}.
  function automatic logic [5:0] exp_ctl();
    logic lu;
    lu = bus.IDEX_MemRead && bus.IDEX_WriteReg != 5'd0 &&
         (bus.IDEX_WriteReg == bus.IFID_Rs || (bus.IFID_UsesRt && bus.IDEX_WriteReg == bus.IFID_Rt));
    if (Reset) return 6'b000110;
    if (m_hold > 0) return 6'b000001;
    if (bus.Branch_Taken) return 6'b111110;
    if (bus.Mul_Start) return 6'b000000;
    if (lu) return 6'b001010;
    if (bus.Jump_ID) return 6'b111100;
    return 6'b111000;
  endfunction
  always @(posedge Clk) begin
    if (Reset) begin
      m_hold <= 0;
      m_err  <= 1'b0;
      m_cnt  <= 0;
    end else begin
      if (!exp_ctl()[5] && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
      if (m_hold > 0) begin
        m_err  <= m_err | bus.Mul_Start | bus.Branch_Taken;
        m_hold <= m_hold - 1;
      end else if (bus.Branch_Taken) begin
        m_err <= m_err | bus.Mul_Start;
      end else if (bus.Mul_Start) begin
        m_hold <= MUL_LATENCY - 2;
      end
    end
  end
  always @(negedge Clk) begin
    if (run) begin
      check("PCWrite", 32'(bus.PCWrite), 32'(exp_ctl()[5]));
      check("IFIDWrite", 32'(bus.IFIDWrite), 32'(exp_ctl()[4]));
      check("IDEXWrite", 32'(bus.IDEXWrite), 32'(exp_ctl()[3]));
      check("IFIDFlush", 32'(bus.IFIDFlush), 32'(exp_ctl()[2]));
      check("IDEXFlush", 32'(bus.IDEXFlush), 32'(exp_ctl()[1]));
      check("State_Busy", 32'(bus.State_Busy), 32'(exp_ctl()[0]));
      check("Protocol_Err", 32'(bus.Protocol_Err), 32'(m_err));
      check("StallCycles", 32'(bus.StallCycles), 32'(m_cnt));
    end
  end
  task automatic step(input int n = 1);
    repeat (n) @(posedge Clk);
    #1;
  endtask
  task automatic drive(input logic br, input logic mul, input logic jmp, input logic mr,
                       input logic [4:0] wr, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ut);
    bus.Branch_Taken  = br;
    bus.Mul_Start     = mul;
    bus.Jump_ID       = jmp;
    bus.IDEX_MemRead  = mr;
    bus.IDEX_WriteReg = wr;
    bus.IFID_Rs       = rs;
    bus.IFID_Rt       = rt;
    bus.IFID_UsesRt   = ut;
    #1;
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
  endtask
  task automatic pulse_reset();
    Reset = 1'b1;
    idle();
    step();
    Reset = 1'b0;
    #1;
  endtask
  initial begin
    Reset = 1'b1;
    idle();
    step();
    run = 1'b1;
    check("rst_pcwrite", 32'(bus.PCWrite), 32'd0);
    check("rst_ifidflush", 32'(bus.IFIDFlush), 32'd1);
    check("rst_idexflush", 32'(bus.IDEXFlush), 32'd1);
    step();
    Reset = 1'b0;
    #1;
    check("post_rst_pcwrite", 32'(bus.PCWrite), 32'd1);
    check("post_rst_ifidwrite", 32'(bus.IFIDWrite), 32'd1);
    check("post_rst_stall", 32'(bus.StallCycles), 32'd0);
    drive(0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0);
    check("lu_rs_pcwrite", 32'(bus.PCWrite), 32'd0);
    check("lu_rs_ifidwrite", 32'(bus.IFIDWrite), 32'd0);
    check("lu_rs_idexflush", 32'(bus.IDEXFlush), 32'd1);
    step();
    idle();
    check("lu_bubble_pcwrite", 32'(bus.PCWrite), 32'd1);
    check("lu_stall_cnt", 32'(bus.StallCycles), 32'd1);
    drive(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0);
    check("zero_reg_pcwrite", 32'(bus.PCWrite), 32'd1);
    drive(0, 0, 0, 1, 5'd8, 5'd1, 5'd8, 0);
    check("rt_unused_pcwrite", 32'(bus.PCWrite), 32'd1);
    drive(0, 0, 0, 1, 5'd8, 5'd1, 5'd8, 1);
    check("rt_used_pcwrite", 32'(bus.PCWrite), 32'd0);
    step();
    drive(0, 0, 1, 1, 5'd8, 5'd8, 5'd0, 0);
    check("lu_jump_ifidflush", 32'(bus.IFIDFlush), 32'd0);
    step();
    drive(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    check("jump_ifidflush", 32'(bus.IFIDFlush), 32'd1);
    check("jump_idexflush", 32'(bus.IDEXFlush), 32'd0);
    step();
    pulse_reset();
    drive(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    check("mul_start_pcwrite", 32'(bus.PCWrite), 32'd0);
    check("mul_start_busy", 32'(bus.State_Busy), 32'd0);
    step();
    idle();
    check("mul_w1_busy", 32'(bus.State_Busy), 32'd1);
    step();
    check("mul_w2_busy", 32'(bus.State_Busy), 32'd1);
    check("mul_w2_pcwrite", 32'(bus.PCWrite), 32'd0);
    step();
    check("mul_done_busy", 32'(bus.State_Busy), 32'd0);
    check("mul_done_pcwrite", 32'(bus.PCWrite), 32'd1);
    check("mul_stall_cnt", 32'(bus.StallCycles), 32'd3);
    drive(1, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0);
    check("br_lu_pcwrite", 32'(bus.PCWrite), 32'd1);
    check("br_lu_ifidflush", 32'(bus.IFIDFlush), 32'd1);
    check("br_lu_idexflush", 32'(bus.IDEXFlush), 32'd1);
    step();
    idle();
    check("br_lu_stall_cnt", 32'(bus.StallCycles), 32'd3);
    drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    check("br_mul_pcwrite", 32'(bus.PCWrite), 32'd1);
    check("br_mul_ifidflush", 32'(bus.IFIDFlush), 32'd1);
    step();
    idle();
    check("br_mul_no_wait", 32'(bus.State_Busy), 32'd0);
    check("br_mul_perr", 32'(bus.Protocol_Err), 32'd1);
    step(3);
    check("perr_sticky", 32'(bus.Protocol_Err), 32'd1);
    pulse_reset();
    check("perr_cleared", 32'(bus.Protocol_Err), 32'd0);
    drive(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step();
    drive(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    check("wait_br_ignored", 32'(bus.IFIDFlush), 32'd0);
    step();
    idle();
    check("wait_br_perr", 32'(bus.Protocol_Err), 32'd1);
    check("wait_br_busy", 32'(bus.State_Busy), 32'd1);
    step();
    pulse_reset();
    drive(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step();
    idle();
    step();
    Reset = 1'b1;
    #1;
    check("rst_in_wait_busy", 32'(bus.State_Busy), 32'd0);
    check("rst_in_wait_pcwrite", 32'(bus.PCWrite), 32'd0);
    step();
    Reset = 1'b0;
    #1;
    check("after_abort_busy", 32'(bus.State_Busy), 32'd0);
    check("after_abort_pcwrite", 32'(bus.PCWrite), 32'd1);
    drive(0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0);
    step(CNT_MAX);
    check("sat_reach", 32'(bus.StallCycles), 32'hFFFF);
    step(4);
    check("sat_hold", 32'(bus.StallCycles), 32'hFFFF);
    idle();
    step();
    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
